// File: rtl/seg_pkg.sv
// Shared segment constants for the 7-segment encode/decode path.
// Pattern bit order is {a,b,c,d,e,f,g}: a is the top bar (MSB), g the middle bar (LSB).
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    // An all-dark digit reads back as blank.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_BLANK   = 4'hA;
    localparam logic [3:0] CODE_INVALID = 4'hF;

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// Reverse of the BCD-to-segment decoder: maps a lit-segment pattern back to
// its BCD digit, 0xA for a dark digit, 0xF for anything unrecognised.
module seg_pattern_to_bcd
    import seg_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic [3:0] code
);

    logic [6:0] pattern;

    assign pattern = {a, b, c, d, e, f, g};

    // Exact-match lookup; partial or corrupted patterns fall through to invalid.
    always_comb begin
        code = CODE_INVALID;
        case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Reads back a multiplexed 7-segment bus and recovers the value shown on each
// digit. A value is committed only after STABLE_COUNT consecutive identical
// visits to that digit; visits to other digits and idle cycles do not break
// a run. Stage 1 registers the pins, stage 2 decodes and updates per-digit
// state, so a sample on the pins in cycle n shows on the outputs in cycle n+2.
module seg_scan_reader
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_COUNT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a,
    input  logic                      b,
    input  logic                      c,
    input  logic                      d,
    input  logic                      e,
    input  logic                      f,
    input  logic                      g,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    input  logic                      clr_err,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      upd,
    output logic [NUM_DIGITS-1:0]     seg_err,
    output logic                      ghost_err
);

    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_COUNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [NUM_DIGITS-1:0] EN_ONE = NUM_DIGITS'(1);

    // Stage 1 sample register
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] en_q;

    // Per-digit state
    logic [3:0]    cand  [NUM_DIGITS];
    logic [CW-1:0] cnt   [NUM_DIGITS];
    logic [3:0]    dig_r [NUM_DIGITS];

    // Stage 2 decode of the registered sample
    logic [3:0]    code;
    logic          en_any;
    logic          en_multi;
    logic          hit;
    logic [IW-1:0] sel;
    logic [3:0]    cur_cand;
    logic [CW-1:0] cur_cnt;
    logic          same;
    logic [CW-1:0] next_cnt;
    logic          commit;
    logic          changed;

    // Register the raw bus every cycle so stage 2 sees a coherent snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= '0;
            en_q  <= '0;
        end else begin
            seg_q <= {a, b, c, d, e, f, g};
            en_q  <= dig_en;
        end
    end

    seg_pattern_to_bcd u_dec (
        .a    (seg_q[6]),
        .b    (seg_q[5]),
        .c    (seg_q[4]),
        .d    (seg_q[3]),
        .e    (seg_q[2]),
        .f    (seg_q[1]),
        .g    (seg_q[0]),
        .code (code)
    );

    assign en_any   = |en_q;
    assign en_multi = (en_q & (en_q - EN_ONE)) != '0;
    assign hit      = en_any && !en_multi;

    // Index of the enabled digit; only meaningful when the sample is one-hot.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (en_q[i]) sel = IW'(i);
        end
    end

    assign cur_cand = cand[sel];
    assign cur_cnt  = cnt[sel];
    assign same     = (code == cur_cand);

    // Run length: extend (saturating) on a repeat, restart at 1 on a new code.
    always_comb begin
        if (!same)                 next_cnt = CNT_ONE;
        else if (cur_cnt == CNT_MAX) next_cnt = cur_cnt;
        else                       next_cnt = cur_cnt + CNT_ONE;
    end

    // Commit only on the transition into STABLE_COUNT, never while saturated.
    // The committed code always equals the sample's code.
    assign commit  = hit && (next_cnt == CNT_MAX) && (!same || (cur_cnt != CNT_MAX));
    assign changed = !digit_valid[sel] || (dig_r[sel] != code);

    // Per-digit candidates, counters, committed values and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand[i]  <= '0;
                cnt[i]   <= '0;
                dig_r[i] <= '0;
            end
            digit_valid <= '0;
            upd         <= 1'b0;
            seg_err     <= '0;
            ghost_err   <= 1'b0;
        end else begin
            upd <= commit && changed;
            if (hit) begin
                cand[sel] <= code;
                cnt[sel]  <= next_cnt;
            end
            if (commit) begin
                dig_r[sel]       <= code;
                digit_valid[sel] <= 1'b1;
            end
            // Clear first so a set event in the same cycle takes priority.
            if (clr_err) begin
                seg_err   <= '0;
                ghost_err <= 1'b0;
            end
            if (commit && (code == CODE_INVALID)) seg_err[sel] <= 1'b1;
            if (en_multi) ghost_err <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
        assign digits[4*gi +: 4] = dig_r[gi];
    end

endmodule
